// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-back controller.
// Imported by the interface, the arbiter and the top.
package rf_wb_arbiter_pkg;

   localparam int RF_NUM = 32;
   localparam int RF_AW  = 5;
   localparam int XLEN   = 32;

   // Requester slot assignment on the write-back bus.
   typedef enum logic [0:0] {
      REQ_EXU = 1'b0,
      REQ_LSU = 1'b1
   } req_id_e;

   // One-hot register select; bit 0 is x0.
   function automatic logic [RF_NUM-1:0] rf_onehot(
      input logic [RF_AW-1:0] a
   );
      return RF_NUM'(1) << a;
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back request bus: N requesters, each with valid/ready,
// destination register and result data packed per requester.
interface rf_wb_arbiter_if #(
   parameter int N_REQ = 2
);
   import rf_wb_arbiter_pkg::*;

   logic [N_REQ-1:0]       i_req_valid;
   logic [N_REQ-1:0]       o_req_ready;
   logic [N_REQ*RF_AW-1:0] i_req_waddr;
   logic [N_REQ*XLEN-1:0]  i_req_wdata;

   modport master (
      output i_req_valid,
      output i_req_waddr,
      output i_req_wdata,
      input  o_req_ready
   );

   modport slave (
      input  i_req_valid,
      input  i_req_waddr,
      input  i_req_wdata,
      output o_req_ready
   );

endinterface

// File: rtl/rf_wb_arbiter_rr.sv
// N-way round-robin arbiter with a last-winner pointer.
// The grant is one-hot, or zero when nothing requests.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         i_rst,
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_idx;
   logic [PW-1:0] w_k;
   logic          w_found;

   // Scan from the slot after the last winner, wrapping, first valid wins.
   always_comb begin
      o_gnt   = '0;
      w_idx   = r_ptr;
      w_found = 1'b0;
      w_k     = '0;
      for (int i = 1; i <= N; i++) begin
         w_k = PW'((int'(r_ptr) + i) % N);
         if (!w_found && i_req[w_k]) begin
            w_found  = 1'b1;
            o_gnt[w_k] = 1'b1;
            w_idx    = w_k;
         end
      end
   end

   // Pointer follows the winner; with no requester it holds.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr <= PW'(N - 1);
      end else if (|i_req) begin
         r_ptr <= w_idx;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Regfile write-back controller: round-robin write port arbitration,
// per-register pending-write scoreboard and decode hazard detection.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             i_rst,
   rf_wb_arbiter_if.slave   wb,
   output logic             o_rf_wen,
   output logic [RF_AW-1:0] o_rf_waddr,
   output logic [XLEN-1:0]  o_rf_wdata,
   input  logic             i_issue_valid,
   input  logic [RF_AW-1:0] i_issue_rd,
   output logic             o_issue_ready,
   input  logic [RF_AW-1:0] i_chk_raddr1,
   input  logic [RF_AW-1:0] i_chk_raddr2,
   output logic             o_hazard
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [N_REQ-1:0]  w_gnt;
   logic              w_xfer;
   logic [RF_AW-1:0]  w_waddr;
   logic [XLEN-1:0]   w_wdata;
   logic              w_dec;
   logic              w_inc;
   logic [RF_NUM-1:0] w_dec_vec;
   logic [RF_NUM-1:0] w_inc_vec;
   logic              w_haz1;
   logic              w_haz2;

   logic [CNT_W-1:0]  r_cnt [RF_NUM];

   rr_arbiter #(
      .N (N_REQ)
   ) u_rr (
      .clk   (clk),
      .i_rst (i_rst),
      .i_req (wb.i_req_valid),
      .o_gnt (w_gnt)
   );

   assign wb.o_req_ready = w_gnt;
   assign w_xfer         = |w_gnt;

   // Steer the granted requester's address and data to the write port.
   always_comb begin
      w_waddr = '0;
      w_wdata = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_gnt[k]) begin
            w_waddr = wb.i_req_waddr[k*RF_AW +: RF_AW];
            w_wdata = wb.i_req_wdata[k*XLEN +: XLEN];
         end
      end
   end

   assign w_dec     = w_xfer & (w_waddr != '0);
   assign w_dec_vec = w_dec ? rf_onehot(w_waddr) : '0;

   // A full counter can still take an issue if the same reg drains now.
   assign o_issue_ready = (i_issue_rd == '0)
                        | (r_cnt[i_issue_rd] != CNT_MAX)
                        | (w_dec & (w_waddr == i_issue_rd));

   assign w_inc     = i_issue_valid & o_issue_ready
                    & (i_issue_rd != '0);
   assign w_inc_vec = w_inc ? rf_onehot(i_issue_rd) : '0;

   // Register the winner; x0 writes are accepted but never enabled.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         o_rf_wen   <= 1'b0;
         o_rf_waddr <= '0;
         o_rf_wdata <= '0;
      end else if (w_xfer) begin
         o_rf_wen   <= (w_waddr != '0);
         o_rf_waddr <= w_waddr;
         o_rf_wdata <= w_wdata;
      end else begin
         o_rf_wen   <= 1'b0;
      end
   end

   // Pending-write counters; x0 stays zero, a stray write saturates at 0.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         for (int r = 0; r < RF_NUM; r++) begin
            r_cnt[r] <= '0;
         end
      end else begin
         for (int r = 1; r < RF_NUM; r++) begin
            if (w_inc_vec[r] && !w_dec_vec[r]) begin
               r_cnt[r] <= r_cnt[r] + 1'b1;
            end else if (w_dec_vec[r] && !w_inc_vec[r]
                         && (r_cnt[r] != '0)) begin
               r_cnt[r] <= r_cnt[r] - 1'b1;
            end
         end
      end
   end

   // A write counts as pending until it leaves the output register.
   assign w_haz1 = (i_chk_raddr1 != '0)
                 & ((r_cnt[i_chk_raddr1] != '0)
                 | (o_rf_wen & (o_rf_waddr == i_chk_raddr1)));
   assign w_haz2 = (i_chk_raddr2 != '0)
                 & ((r_cnt[i_chk_raddr2] != '0)
                 | (o_rf_wen & (o_rf_waddr == i_chk_raddr2)));

   assign o_hazard = w_haz1 | w_haz2;

endmodule
